// File: rtl/lc3b_pkg.sv
// rtl/lc3b_pkg.sv - LC-3b instruction field positions and opcode constants
package lc3b_pkg;

   localparam int LC3B_OPC_MSB     = 15;
   localparam int LC3B_OPC_LSB     = 12;
   localparam int LC3B_DR_MSB      = 11;
   localparam int LC3B_DR_LSB      = 9;
   localparam int LC3B_SR1_MSB     = 8;
   localparam int LC3B_SR1_LSB     = 6;
   localparam int LC3B_IMM_SEL_BIT = 5;

   localparam logic [3:0] OP_BR   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LDB  = 4'h2;
   localparam logic [3:0] OP_STB  = 4'h3;
   localparam logic [3:0] OP_JSR  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_LDW  = 4'h6;
   localparam logic [3:0] OP_STW  = 4'h7;
   localparam logic [3:0] OP_RTI  = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_RSVA = 4'hA;
   localparam logic [3:0] OP_RSVB = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_SHF  = 4'hD;
   localparam logic [3:0] OP_LEA  = 4'hE;
   localparam logic [3:0] OP_TRAP = 4'hF;

endpackage

// File: rtl/ir_field_decode.sv
// rtl/ir_field_decode.sv - combinational LC-3b field slicer
// Ports:
//   i_instr   in  WIDTH  instruction word
//   o_opcode  out 4      instr[15:12]
//   o_dr      out 3      instr[11:9]
//   o_sr1     out 3      instr[8:6]
//   o_imm_sel out 1      instr[5]
module ir_field_decode
   import lc3b_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_instr,
   output logic [3:0]       o_opcode,
   output logic [2:0]       o_dr,
   output logic [2:0]       o_sr1,
   output logic             o_imm_sel
);

   // Remaining bits are decoded elsewhere; folded here so they are not flagged as dangling.
   logic w_unused_bits;
   assign w_unused_bits = ^i_instr;

   assign o_opcode  = i_instr[LC3B_OPC_MSB:LC3B_OPC_LSB];
   assign o_dr      = i_instr[LC3B_DR_MSB:LC3B_DR_LSB];
   assign o_sr1     = i_instr[LC3B_SR1_MSB:LC3B_SR1_LSB];
   assign o_imm_sel = i_instr[LC3B_IMM_SEL_BIT];

endmodule

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - DEPTH-entry clocked instruction register queue with flush
// Ports:
//   clk, reset (sync, active-high), flush (drop all entries)
//   in_valid/in_ready/in_instr/in_pc     fetch side
//   out_valid/out_ready/out_instr/out_pc decode side, outputs zero when empty
//   opcode/dr/sr1/imm_sel                fields of the gated head instruction
//   count                                occupancy 0..DEPTH
module ir_queue
   import lc3b_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_instr,
   input  logic [ADDR_W-1:0]          in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_instr,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [3:0]                 opcode,
   output logic [2:0]                 dr,
   output logic [2:0]                 sr1,
   output logic                       imm_sel,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [WIDTH-1:0]  instr;
   } ir_entry_t;

   ir_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic      w_push;
   logic      w_pop;
   ir_entry_t w_head;

   // Handshakes depend only on registered count, so no in->out or out_ready->in_ready paths exist.
   assign in_ready  = (r_count != CNT_W'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         // wr_ptr is kept; jumping rd_ptr to it empties the ring without rewinding storage.
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage is never reset; stale contents are hidden by out_valid gating.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign out_instr = out_valid ? w_head.instr : '0;
   assign out_pc    = out_valid ? w_head.pc    : '0;
   assign count     = r_count;

   ir_field_decode #(.WIDTH(WIDTH)) u_field_decode (
      .i_instr   (out_instr),
      .o_opcode  (opcode),
      .o_dr      (dr),
      .o_sr1     (sr1),
      .o_imm_sel (imm_sel)
   );

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - self-checking bench for ir_queue
module tb_ir_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_instr = '0;
   logic [15:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic [3:0]  opcode;
   logic [2:0]  dr;
   logic [2:0]  sr1;
   logic        imm_sel;
   logic [2:0]  count;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } ent_t;

   ent_t mq[$];

   typedef struct {
      bit          rst;
      bit          fl;
      bit          iv;
      bit          ordy;
      logic [15:0] instr;
      bit          exp_valid;
      logic [15:0] exp_instr;
      int          exp_count;
   } vec_t;

   vec_t vecs[$];

   ir_queue #(.WIDTH(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .opcode    (opcode),
      .dr        (dr),
      .sr1       (sr1),
      .imm_sel   (imm_sel),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   function automatic logic [15:0] pc_of(input logic [15:0] instr);
      return (instr == 16'h1261) ? 16'h3000 : ~instr;
   endfunction

   // Compare all outputs with what the reference queue says they should be.
   task automatic check_model(input string tag);
      logic [15:0] ei, ep;
      ei = '0; ep = '0;
      if (mq.size() > 0) begin
         ei = mq[0].instr;
         ep = mq[0].pc;
      end
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < DEPTH));
      chk({tag, ".count"},     32'(count),     32'(mq.size()));
      chk({tag, ".out_instr"}, 32'(out_instr), 32'(ei));
      chk({tag, ".out_pc"},    32'(out_pc),    32'(ep));
      chk({tag, ".fields"}, {20'h0, opcode, dr, sr1, imm_sel, 1'b0},
          {20'h0, ei[15:12], ei[11:9], ei[8:6], ei[5], 1'b0});
   endtask

   // Drive one cycle: check against model, clock, advance model.
   task automatic step(input string tag, input bit r, input bit f, input bit iv,
                       input logic [15:0] ins, input logic [15:0] pc, input bit ordy);
      bit push, pop;
      reset = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
      #1;
      if (!r) check_model(tag);
      @(posedge clk);
      #1;
      if (r || f) begin
         mq.delete();
      end else begin
         push = iv && (mq.size() < DEPTH);
         pop  = (mq.size() > 0) && ordy;
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back('{pc: pc, instr: ins});
      end
   endtask

   function automatic vec_t mk(bit rst, bit fl, bit iv, bit ordy, logic [15:0] instr,
                               bit ev, logic [15:0] ei, int ec);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.instr = instr;
      v.exp_valid = ev; v.exp_instr = ei; v.exp_count = ec;
      return v;
   endfunction

   initial begin
      logic [15:0] ep;
      string tag;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();

      vecs.push_back(mk(1,0,0,0,16'h0000, 0,16'h0000,0));
      vecs.push_back(mk(1,0,0,0,16'h0000, 0,16'h0000,0));
      vecs.push_back(mk(0,0,1,0,16'h1261, 1,16'h1261,1));
      vecs.push_back(mk(0,0,0,1,16'h0000, 0,16'h0000,0));
      vecs.push_back(mk(0,0,1,0,16'hA001, 1,16'hA001,1));
      vecs.push_back(mk(0,0,1,0,16'hA002, 1,16'hA001,2));
      vecs.push_back(mk(0,0,1,0,16'hA003, 1,16'hA001,3));
      vecs.push_back(mk(0,0,1,0,16'hA004, 1,16'hA001,4));
      vecs.push_back(mk(0,0,1,0,16'hA005, 1,16'hA001,4));
      vecs.push_back(mk(0,0,1,1,16'hB001, 1,16'hA002,3));
      vecs.push_back(mk(0,0,1,1,16'hB001, 1,16'hA003,3));
      vecs.push_back(mk(0,0,1,1,16'hB002, 1,16'hA004,3));
      vecs.push_back(mk(0,0,1,1,16'hB003, 1,16'hB001,3));
      vecs.push_back(mk(0,0,1,1,16'hB004, 1,16'hB002,3));
      vecs.push_back(mk(0,0,0,1,16'h0000, 1,16'hB003,2));
      vecs.push_back(mk(0,0,1,1,16'hB005, 1,16'hB004,2));
      vecs.push_back(mk(0,0,1,0,16'hB006, 1,16'hB004,3));
      vecs.push_back(mk(0,1,1,1,16'hC000, 0,16'h0000,0));
      vecs.push_back(mk(0,0,1,0,16'hD000, 1,16'hD000,1));
      vecs.push_back(mk(0,0,1,0,16'hD001, 1,16'hD000,2));
      vecs.push_back(mk(0,0,1,0,16'hD002, 1,16'hD000,3));
      vecs.push_back(mk(1,0,1,1,16'hD003, 0,16'h0000,0));
      vecs.push_back(mk(0,0,0,0,16'h0000, 0,16'h0000,0));

      for (int i = 0; i < vecs.size(); i++) begin
         tag = $sformatf("vec%0d", i);
         step(tag, vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].instr,
              pc_of(vecs[i].instr), vecs[i].ordy);
         ep = vecs[i].exp_valid ? pc_of(vecs[i].exp_instr) : 16'h0000;
         chk({tag, ".tbl_valid"}, 32'(out_valid), 32'(vecs[i].exp_valid));
         chk({tag, ".tbl_instr"}, 32'(out_instr), 32'(vecs[i].exp_instr));
         chk({tag, ".tbl_pc"},    32'(out_pc),    32'(ep));
         chk({tag, ".tbl_count"}, 32'(count),     32'(vecs[i].exp_count));
         chk({tag, ".tbl_opcode"}, 32'(opcode),   32'(vecs[i].exp_instr[15:12]));
      end

      // Flushed word must never surface: after draining the post-flush D-stream, nothing is C000.
      for (int i = 0; i < 4; i++) begin
         step("flushchk", 0, 0, 0, 16'h0, 16'h0, 1);
         if (out_valid) chk("flushchk.noC000", 32'(out_instr == 16'hC000), 32'd0);
      end

      // Output stability under backpressure.
      step("stab0", 0, 0, 1, 16'h1A2B, 16'h0100, 0);
      step("stab1", 0, 0, 1, 16'h2B3C, 16'h0102, 0);
      for (int i = 0; i < 3; i++) begin
         step("stab", 0, 0, 1, 16'(16'h7000 + i), 16'h0200, 0);
         chk("stab.hold", 32'(out_instr), 32'h1A2B);
      end

      for (int i = 0; i < 1500; i++) begin
         step("rnd", ($urandom_range(63) == 0), ($urandom_range(15) == 0),
              bit'($urandom_range(1)), 16'($urandom), 16'($urandom),
              bit'($urandom_range(3) != 0 ? $urandom_range(1) : 0));
      end
      check_model("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
